// File: rtl/tl_a_queue.sv
// rtl/tl_a_queue.sv - parametrised TileLink A-channel queue with flow/pipe modes and occupancy
module tl_a_queue #(
  parameter int DEPTH    = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 3,
  parameter int SIZE_W   = 4,
  parameter bit FLOW     = 1'b0,
  parameter bit PIPE     = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_enq_valid,
  output logic                          io_enq_ready,
  input  logic [2:0]                    io_enq_bits_opcode,
  input  logic [2:0]                    io_enq_bits_param,
  input  logic [SIZE_W-1:0]             io_enq_bits_size,
  input  logic [SOURCE_W-1:0]           io_enq_bits_source,
  input  logic [ADDR_W-1:0]             io_enq_bits_address,
  input  logic [DATA_W/8-1:0]           io_enq_bits_mask,
  input  logic [DATA_W-1:0]             io_enq_bits_data,
  input  logic                          io_enq_bits_corrupt,
  output logic                          io_deq_valid,
  input  logic                          io_deq_ready,
  output logic [2:0]                    io_deq_bits_opcode,
  output logic [2:0]                    io_deq_bits_param,
  output logic [SIZE_W-1:0]             io_deq_bits_size,
  output logic [SOURCE_W-1:0]           io_deq_bits_source,
  output logic [ADDR_W-1:0]             io_deq_bits_address,
  output logic [DATA_W/8-1:0]           io_deq_bits_mask,
  output logic [DATA_W-1:0]             io_deq_bits_data,
  output logic                          io_deq_bits_corrupt,
  output logic [$clog2(DEPTH+1)-1:0]    io_count
);

  localparam int MASK_W  = DATA_W / 8;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 3 + 3 + SIZE_W + SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;

  logic [PTR_W-1:0]   enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0]   deq_ptr_q, deq_ptr_d;
  logic               maybe_full_q, maybe_full_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [ENTRY_W-1:0] enq_entry, deq_entry;
  logic               ptr_match, empty, full, bypass;
  logic               do_enq, do_deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign enq_entry = {io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
                      io_enq_bits_source, io_enq_bits_address, io_enq_bits_mask,
                      io_enq_bits_data, io_enq_bits_corrupt};

  assign ptr_match = (enq_ptr_q == deq_ptr_q);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match &  maybe_full_q;
  assign bypass    = FLOW & empty;

  assign io_enq_ready = ~full | (PIPE & io_deq_ready);
  assign io_deq_valid = ~empty | (FLOW & io_enq_valid);

  // An empty flow queue hands the beat straight through without touching storage.
  assign do_enq = io_enq_valid & io_enq_ready & ~(bypass & io_deq_ready);
  assign do_deq = io_deq_valid & io_deq_ready & ~bypass;

  assign deq_entry = bypass ? enq_entry : mem_q[deq_ptr_q];
  assign {io_deq_bits_opcode, io_deq_bits_param, io_deq_bits_size,
          io_deq_bits_source, io_deq_bits_address, io_deq_bits_mask,
          io_deq_bits_data, io_deq_bits_corrupt} = deq_entry;

  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (do_enq) enq_ptr_d = ptr_inc(enq_ptr_q);
    if (do_deq) deq_ptr_d = ptr_inc(deq_ptr_q);
    if (do_enq != do_deq) maybe_full_d = do_enq;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // When full in pipe mode the write lands in the slot the head is leaving this edge.
  always_ff @(posedge clock) begin
    if (reset && do_enq) mem_q[enq_ptr_q] <= enq_entry;
  end

  always_comb begin
    io_count = '0;
    if (full)
      io_count = CNT_W'(DEPTH);
    else if (enq_ptr_q >= deq_ptr_q)
      io_count = CNT_W'(enq_ptr_q) - CNT_W'(deq_ptr_q);
    else
      io_count = CNT_W'(DEPTH) + CNT_W'(enq_ptr_q) - CNT_W'(deq_ptr_q);
  end

  a_no_enq_when_not_ready: assert property (@(posedge clock) disable iff (!reset)
    (io_enq_valid && !io_enq_ready) |-> !do_enq);
  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    io_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_tl_a_queue.sv
// tb/tb_tl_a_queue.sv - table-driven scoreboard bench for tl_a_queue (base, pipe and flow instances)
module tb_tl_a_queue;

  localparam int W = 190;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic [2:0]   opcode, param, source;
  logic [3:0]   size;
  logic [31:0]  address;
  logic [15:0]  mask;
  logic [127:0] data;
  logic         corrupt;
  logic [2:0]   ev, dr;

  logic er0, er1, er2, dv0, dv1, dv2, cr0, cr1, cr2;
  logic [1:0] cnt0, cnt1, cnt2;
  logic [2:0] op0, op1, op2, pa0, pa1, pa2, src0, src1, src2;
  logic [3:0] sz0, sz1, sz2;
  logic [31:0] ad0, ad1, ad2;
  logic [15:0] mk0;
  logic [7:0] mk1, mk2;
  logic [127:0] dt0;
  logic [63:0] dt1, dt2;

  int total = 0;
  int bad = 0;

  tl_a_queue #(.DEPTH(3), .DATA_W(128)) u_base (
    .clock(clock), .reset(reset),
    .io_enq_valid(ev[0]), .io_enq_ready(er0),
    .io_enq_bits_opcode(opcode), .io_enq_bits_param(param), .io_enq_bits_size(size),
    .io_enq_bits_source(source), .io_enq_bits_address(address), .io_enq_bits_mask(mask),
    .io_enq_bits_data(data), .io_enq_bits_corrupt(corrupt),
    .io_deq_valid(dv0), .io_deq_ready(dr[0]),
    .io_deq_bits_opcode(op0), .io_deq_bits_param(pa0), .io_deq_bits_size(sz0),
    .io_deq_bits_source(src0), .io_deq_bits_address(ad0), .io_deq_bits_mask(mk0),
    .io_deq_bits_data(dt0), .io_deq_bits_corrupt(cr0), .io_count(cnt0));

  tl_a_queue #(.DEPTH(2), .PIPE(1'b1)) u_pipe (
    .clock(clock), .reset(reset),
    .io_enq_valid(ev[1]), .io_enq_ready(er1),
    .io_enq_bits_opcode(opcode), .io_enq_bits_param(param), .io_enq_bits_size(size),
    .io_enq_bits_source(source), .io_enq_bits_address(address), .io_enq_bits_mask(mask[7:0]),
    .io_enq_bits_data(data[63:0]), .io_enq_bits_corrupt(corrupt),
    .io_deq_valid(dv1), .io_deq_ready(dr[1]),
    .io_deq_bits_opcode(op1), .io_deq_bits_param(pa1), .io_deq_bits_size(sz1),
    .io_deq_bits_source(src1), .io_deq_bits_address(ad1), .io_deq_bits_mask(mk1),
    .io_deq_bits_data(dt1), .io_deq_bits_corrupt(cr1), .io_count(cnt1));

  tl_a_queue #(.DEPTH(2), .FLOW(1'b1)) u_flow (
    .clock(clock), .reset(reset),
    .io_enq_valid(ev[2]), .io_enq_ready(er2),
    .io_enq_bits_opcode(opcode), .io_enq_bits_param(param), .io_enq_bits_size(size),
    .io_enq_bits_source(source), .io_enq_bits_address(address), .io_enq_bits_mask(mask[7:0]),
    .io_enq_bits_data(data[63:0]), .io_enq_bits_corrupt(corrupt),
    .io_deq_valid(dv2), .io_deq_ready(dr[2]),
    .io_deq_bits_opcode(op2), .io_deq_bits_param(pa2), .io_deq_bits_size(sz2),
    .io_deq_bits_source(src2), .io_deq_bits_address(ad2), .io_deq_bits_mask(mk2),
    .io_deq_bits_data(dt2), .io_deq_bits_corrupt(cr2), .io_count(cnt2));

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic set_fields(input logic [31:0] a);
    address = a;
    data    = {4{a}};
    mask    = a[15:0] ^ 16'h5a5a;
    source  = a[4:2];
    opcode  = a[2:0];
    param   = a[5:3];
    size    = a[3:0];
    corrupt = a[3];
  endtask

  // Scoreboard: push on every accepted enq, pop and compare on every deq beat.
  logic [189:0] sb0[$];
  logic [117:0] sb1[$];
  logic [117:0] sb2[$];
  logic [189:0] e_full;
  logic [117:0] e_half;
  assign e_full = {opcode, param, size, source, address, mask, data, corrupt};
  assign e_half = {opcode, param, size, source, address, mask[7:0], data[63:0], corrupt};

  task automatic underflow(input string name);
    total++;
    bad++;
    $display("FAIL %s: deq beat with no expected entry", name);
  endtask

  always @(negedge clock) begin
    #3;
    if (!reset) begin
      sb0.delete();
      sb1.delete();
      sb2.delete();
    end else begin
      if (ev[0] && er0) sb0.push_back(e_full);
      if (dv0 && dr[0]) begin
        if (sb0.size() == 0) underflow("sb_base");
        else chk("sb_base", {op0, pa0, sz0, src0, ad0, mk0, dt0, cr0}, sb0.pop_front());
      end
      if (ev[1] && er1) sb1.push_back(e_half);
      if (dv1 && dr[1]) begin
        if (sb1.size() == 0) underflow("sb_pipe");
        else chk("sb_pipe", W'({op1, pa1, sz1, src1, ad1, mk1, dt1, cr1}), W'(sb1.pop_front()));
      end
      if (ev[2] && er2) sb2.push_back(e_half);
      if (dv2 && dr[2]) begin
        if (sb2.size() == 0) underflow("sb_flow");
        else chk("sb_flow", W'({op2, pa2, sz2, src2, ad2, mk2, dt2, cr2}), W'(sb2.pop_front()));
      end
    end
  end

  typedef struct {
    int          inst;
    logic        ev;
    logic        dr;
    logic [31:0] addr;
    logic        er;
    logic        dv;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int inst, input logic e, input logic d, input logic [31:0] a,
                     input logic x_er, input logic x_dv, input logic [1:0] x_cnt);
    vec_t v;
    v.inst = inst; v.ev = e; v.dr = d; v.addr = a;
    v.er = x_er; v.dv = x_dv; v.cnt = x_cnt;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic ger, gdv;
    logic [1:0] gcnt;
    @(negedge clock);
    ev = '0;
    dr = '0;
    ev[v.inst] = v.ev;
    dr[v.inst] = v.dr;
    set_fields(v.addr);
    #1;
    ger  = (v.inst == 0) ? er0  : (v.inst == 1) ? er1  : er2;
    gdv  = (v.inst == 0) ? dv0  : (v.inst == 1) ? dv1  : dv2;
    gcnt = (v.inst == 0) ? cnt0 : (v.inst == 1) ? cnt1 : cnt2;
    chk({tag, "_enq_ready"}, W'(ger), W'(v.er));
    chk({tag, "_deq_valid"}, W'(gdv), W'(v.dv));
    chk({tag, "_count"}, W'(gcnt), W'(v.cnt));
  endtask

  initial begin
    reset = 1'b0;
    ev = '0;
    dr = '0;
    set_fields(32'h10);

    // Reset held with enq_valid high: nothing may be written.
    ev = 3'b111;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_er_base", W'(er0), W'(1)); chk("rst_dv_base", W'(dv0), W'(0)); chk("rst_cnt_base", W'(cnt0), W'(0));
    chk("rst_er_pipe", W'(er1), W'(1)); chk("rst_dv_pipe", W'(dv1), W'(0)); chk("rst_cnt_pipe", W'(cnt1), W'(0));
    chk("rst_er_flow", W'(er2), W'(1)); chk("rst_dv_flow", W'(dv2), W'(1)); chk("rst_cnt_flow", W'(cnt2), W'(0));
    @(negedge clock);
    ev = '0;
    reset = 1'b1;
    #1;
    chk("post_rst_cnt_base", W'(cnt0), W'(0));
    chk("post_rst_dv_base", W'(dv0), W'(0));
    chk("post_rst_dv_flow", W'(dv2), W'(0));

    // Fill/drain on DEPTH=3, then pipe overlap when full, then flow bypass and fill.
    add(0, 1, 0, 32'h100, 1, 0, 0);
    add(0, 1, 0, 32'h104, 1, 1, 1);
    add(0, 1, 0, 32'h108, 1, 1, 2);
    add(0, 1, 0, 32'h10C, 0, 1, 3);
    add(0, 1, 0, 32'h10C, 0, 1, 3);
    add(0, 1, 1, 32'h10C, 0, 1, 3);
    add(0, 1, 1, 32'h10C, 1, 1, 2);
    add(0, 0, 1, 32'h0,   1, 1, 2);
    add(0, 0, 1, 32'h0,   1, 1, 1);
    add(0, 0, 1, 32'h0,   1, 0, 0);
    add(1, 1, 0, 32'h300, 1, 0, 0);
    add(1, 1, 0, 32'h304, 1, 1, 1);
    add(1, 1, 0, 32'h308, 0, 1, 2);
    add(1, 1, 1, 32'h308, 1, 1, 2);
    add(1, 0, 1, 32'h0,   1, 1, 2);
    add(1, 0, 1, 32'h0,   1, 1, 1);
    add(1, 0, 1, 32'h0,   1, 0, 0);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Corrupt/mask/source passthrough on the 128-bit instance.
    @(negedge clock);
    ev = 3'b001;
    dr = '0;
    set_fields(32'h500);
    source  = 3'd5;
    mask    = 16'hFFFF;
    corrupt = 1'b1;
    data    = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    @(negedge clock);
    ev = '0;
    #1;
    chk("pass_corrupt", W'(cr0), W'(1));
    chk("pass_mask", W'(mk0), W'(16'hFFFF));
    chk("pass_source", W'(src0), W'(3'd5));
    chk("pass_data", W'(dt0), W'(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210));
    chk("pass_count", W'(cnt0), W'(1));
    @(negedge clock);
    dr = 3'b001;
    @(negedge clock);
    dr = '0;
    #1;
    chk("pass_drained", W'(cnt0), W'(0));

    // Simultaneous enq/deq at count=1 for 10 cycles.
    tbl.delete();
    add(0, 1, 0, 32'h600, 1, 0, 0);
    for (int i = 1; i <= 10; i++) add(0, 1, 1, 32'h600 + 32'(4 * i), 1, 1, 1);
    add(0, 0, 1, 32'h0, 1, 1, 1);
    add(0, 0, 1, 32'h0, 1, 0, 0);
    add(2, 1, 1, 32'hDEADBEEF, 1, 1, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("sim%0d", i));
      if (tbl[i].addr == 32'hDEADBEEF) chk("flow_bypass_data", W'(dt2[31:0]), W'(32'hDEADBEEF));
    end

    tbl.delete();
    add(2, 0, 0, 32'h0,   1, 0, 0);
    add(2, 1, 0, 32'h400, 1, 1, 0);
    add(2, 1, 0, 32'h404, 1, 1, 1);
    add(2, 1, 0, 32'h408, 0, 1, 2);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("flow%0d", i));

    // Mid-burst reset at count=2 empties the queue at once.
    @(negedge clock);
    ev = '0;
    reset = 1'b0;
    #1;
    chk("midrst_count", W'(cnt2), W'(0));
    chk("midrst_dv", W'(dv2), W'(0));
    chk("midrst_er", W'(er2), W'(1));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("after_midrst_count", W'(cnt2), W'(0));
    chk("after_midrst_dv", W'(dv2), W'(0));

    @(negedge clock);
    #5;
    chk("sb_base_empty", W'(sb0.size()), W'(0));
    chk("sb_pipe_empty", W'(sb1.size()), W'(0));
    chk("sb_flow_empty", W'(sb2.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_a_queue.md
Name: tl_a_queue

Overview:
- Parametrised TileLink A-channel buffering queue; next generation of the fixed 2-entry, 64-bit-data A queue.
- Generalised in depth (any value ≥1, including non-power-of-2), address/data/source width, and optional flow and pipe modes.
- Carries the corrupt bit end to end instead of tying it to 0, and reports occupancy.
- Sits between a TileLink client and crossbar/adapter, one per A channel.

Parameters:
DEPTH, 2, number of entries; ≥1, need not be a power of 2
ADDR_W, 32, address width
DATA_W, 64, data width; MASK_W = DATA_W/8 (derived)
SOURCE_W, 3, source ID width
SIZE_W, 4, size field width
FLOW, 0, 1 = empty queue bypasses enq to deq combinationally
PIPE, 0, 1 = enq_ready also asserted when full and deq fires this cycle

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
io_enq_valid  in  1  enqueue request
io_enq_ready  out  1  queue can accept
io_enq_bits_opcode/param  in  3/3  A opcode, param
io_enq_bits_size  in  SIZE_W  size
io_enq_bits_source  in  SOURCE_W  source ID
io_enq_bits_address  in  ADDR_W  address
io_enq_bits_mask  in  MASK_W  byte mask
io_enq_bits_data  in  DATA_W  data
io_enq_bits_corrupt  in  1  corrupt flag
io_deq_valid  out  1  head entry valid
io_deq_ready  in  1  consumer accepts
io_deq_bits_*  out  same widths as enq  head entry fields, incl. corrupt
io_count  out  clog2(DEPTH+1)  occupancy 0..DEPTH

Behaviour:
- State:
  - enq_ptr, deq_ptr: width max(1, clog2(DEPTH)); both held at 0 when DEPTH=1.
  - maybe_full: 1 bit.
  - Storage: DEPTH entries of packed fields. Not reset.
- Reset (reset=0, async) clears enq_ptr=0, deq_ptr=0, maybe_full=0, so:
  - io_enq_ready=1, io_count=0.
  - io_deq_valid=0 (FLOW=1: io_deq_valid follows io_enq_valid).
  - io_deq_bits undefined.
- Reset deassertion is synchronised externally; the block only requires async assert.
- Mid-operation reset discards all entries; no deq beat is issued in the reset cycle.
- Derived status:
  - ptr_match = enq_ptr==deq_ptr
  - empty = ptr_match & ~maybe_full
  - full = ptr_match & maybe_full
- Handshakes (transfer occurs when valid & ready at the rising edge):
  - io_enq_ready = ~full, or (~full | io_deq_ready) when PIPE=1.
  - io_deq_valid = ~empty, or (~empty | io_enq_valid) when FLOW=1.
  - io_deq_valid never depends on io_deq_ready; io_enq_ready depends on io_deq_ready only in PIPE mode.
- Read path:
  - io_deq_bits = storage[deq_ptr] asynchronously, so zero-cycle read latency from head.
  - FLOW=1 and empty: io_deq_bits = io_enq_bits directly.
- Write: do_enq writes all fields, including corrupt, to storage[enq_ptr].
- Flow bypass: FLOW=1, empty, and io_deq_ready=1 gives do_enq=0 and do_deq=0. The beat passes through, storage and pointers are unchanged, and io_count stays 0.
- Pointer advance:
  - do_enq increments enq_ptr; do_deq increments deq_ptr.
  - Each wraps from DEPTH-1 to 0 (explicit compare, not natural overflow).
- maybe_full <= do_enq when do_enq != do_deq; otherwise it holds.
  - Simultaneous enq+deq: both pointers advance, occupancy unchanged.
  - Simultaneous enq+deq when full (PIPE): the write lands in the slot being freed. The head is read combinationally before the edge, so data is preserved.
- io_count:
  - full: DEPTH; empty: 0.
  - enq_ptr ≥ deq_ptr: enq_ptr-deq_ptr.
  - Otherwise: DEPTH+enq_ptr-deq_ptr.
- Ordering: strict FIFO; no reordering, merging or dropping. Fields are never modified.
- Assertions (simulation only): no enq while io_enq_ready=0 is accepted; io_count ≤ DEPTH.

Test Plan:
1. Reset default (DEPTH=2): hold reset=0 for 3 cycles with enq_valid=1 -> enq_ready=1, deq_valid=0, count=0; no writes occur.
2. Fill/drain (DEPTH=3, non-pow2): enqueue addresses 0x100, 0x104, 0x108, 0x10C with deq_ready=0.
   - Required: the first three are accepted, count=3, enq_ready=0, and 0x10C stalls.
   - Then set deq_ready=1. Required: deq yields 0x100, 0x104, 0x108, 0x10C in order and pointers wrap 2→0.
3. Corrupt and field passthrough (DATA_W=128): enqueue corrupt=1, mask=0xFFFF, source=5 -> deq shows identical corrupt, mask and source.
4. Simultaneous enq/deq at count=1 for 10 cycles -> count stays 1 and output order matches input order.
5. PIPE=1, full DEPTH=2, deq_ready=1 and enq_valid=1 same cycle -> enq_ready=1, both fire, count stays 2, and the new beat appears after the old entries.
6. FLOW=1, empty, enq_valid=1, deq_ready=1 with data 0xDEADBEEF -> same-cycle deq_valid=1 with data 0xDEADBEEF, count remains 0. Also assert reset=0 mid-burst at count=2 -> count=0, deq_valid=0 immediately.
